// File: rtl/instr_encoder.sv
// Instruction encoder / program loader: packs symbolic instructions into MIPS words
// and writes them to instruction memory. Optional `CHECKSUM_EN adds a running XOR csum.
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm16,
  input  logic [25:0]       target,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  input  logic              im_ack,
  output logic              err_illegal,
  output logic              full,
`ifdef CHECKSUM_EN
  output logic [31:0]       csum,
`endif
  output logic [15:0]       word_count
);

  typedef enum logic [1:0] {S_IDLE, S_ENC, S_WR, S_FULL} state_t;

  state_t      state;
  logic [5:0]  l_mnem;
  logic [4:0]  l_rs, l_rt, l_rd, l_shamt;
  logic [15:0] l_imm;
  logic [25:0] l_target;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic [5:0]  funct, op;
  logic [4:0]  rs_f, rt_f, rd_f, sh_f;
  logic        last_word;

  assign last_word = ({1'b0, word_count} + 17'd1) == 17'(MAX_WORDS);

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    funct     = '0;
    op        = '0;
    rs_f      = l_rs;
    rt_f      = l_rt;
    rd_f      = l_rd;
    sh_f      = '0;
    if (l_mnem <= 6'd16) begin
      case (l_mnem)
        6'd0:    funct = 6'h20;
        6'd1:    funct = 6'h21;
        6'd2:    funct = 6'h22;
        6'd3:    funct = 6'h23;
        6'd4:    funct = 6'h24;
        6'd5:    funct = 6'h25;
        6'd6:    funct = 6'h26;
        6'd7:    funct = 6'h27;
        6'd8:    funct = 6'h2A;
        6'd9:    funct = 6'h2B;
        6'd10:   funct = 6'h00;
        6'd11:   funct = 6'h02;
        6'd12:   funct = 6'h03;
        6'd13:   funct = 6'h04;
        6'd14:   funct = 6'h06;
        6'd15:   funct = 6'h07;
        default: funct = 6'h08;
      endcase
      // Immediate shifts take shamt and no rs; jr keeps only rs.
      if (l_mnem >= 6'd10 && l_mnem <= 6'd12) begin
        rs_f = '0;
        sh_f = l_shamt;
      end
      if (l_mnem == 6'd16) begin
        rt_f = '0;
        rd_f = '0;
      end
      enc_word = {6'h00, rs_f, rt_f, rd_f, sh_f, funct};
    end else if (l_mnem <= 6'd28) begin
      case (l_mnem)
        6'd17:   op = 6'h08;
        6'd18:   op = 6'h09;
        6'd19:   op = 6'h0C;
        6'd20:   op = 6'h0D;
        6'd21:   op = 6'h0E;
        6'd22:   op = 6'h0F;
        6'd23:   op = 6'h23;
        6'd24:   op = 6'h2B;
        6'd25:   op = 6'h04;
        6'd26:   op = 6'h05;
        6'd27:   op = 6'h0A;
        default: op = 6'h0B;
      endcase
      if (l_mnem == 6'd22) rs_f = '0;
      enc_word = {op, rs_f, l_rt, l_imm};
    end else if (l_mnem <= 6'd30) begin
      op       = (l_mnem == 6'd29) ? 6'h02 : 6'h03;
      enc_word = {op, l_target};
    end else begin
      enc_legal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      im_we       <= 1'b0;
      im_addr     <= BASE_ADDR;
      im_wdata    <= '0;
      err_illegal <= 1'b0;
      full        <= 1'b0;
      word_count  <= '0;
      l_mnem      <= '0;
      l_rs        <= '0;
      l_rt        <= '0;
      l_rd        <= '0;
      l_shamt     <= '0;
      l_imm       <= '0;
      l_target    <= '0;
`ifdef CHECKSUM_EN
      csum        <= '0;
`endif
    end else if (clear) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      im_we       <= 1'b0;
      im_addr     <= BASE_ADDR;
      err_illegal <= 1'b0;
      full        <= 1'b0;
      word_count  <= '0;
`ifdef CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      err_illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            l_mnem   <= mnem;
            l_rs     <= rs;
            l_rt     <= rt;
            l_rd     <= rd;
            l_shamt  <= shamt;
            l_imm    <= imm16;
            l_target <= target;
            in_ready <= 1'b0;
            state    <= S_ENC;
          end
        end
        S_ENC: begin
          if (enc_legal) begin
            im_wdata <= enc_word;
            im_we    <= 1'b1;
            state    <= S_WR;
          end else begin
            err_illegal <= 1'b1;
            in_ready    <= 1'b1;
            state       <= S_IDLE;
          end
        end
        S_WR: begin
          if (im_ack) begin
            im_we      <= 1'b0;
            im_addr    <= im_addr + ADDR_W'(4);
            word_count <= word_count + 16'd1;
`ifdef CHECKSUM_EN
            csum       <= csum ^ im_wdata;
`endif
            if (last_word) begin
              full  <= 1'b1;
              state <= S_FULL;
            end else begin
              in_ready <= 1'b1;
              state    <= S_IDLE;
            end
          end
        end
        S_FULL: begin
          in_ready <= 1'b0;
          full     <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
